fwd_hazard_ctrl: RTL and testbench

//  Sequences the EX-stage operand-forwarding muxes and the load-use stall of the 5-stage pipeline.

---
 rtl/fwd_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and load-use stall controller for the EX stage.
// Tracks shadow destination/flag entries for the EX and MEM stages and registers per-operand
// forwarding selects so they line up with the instruction once it reaches EX. A small RUN/HOLD
// FSM inserts LU_STALL bubbles per load-use hazard. A taken branch flushes ID and cancels any
// pending hold.
// The WB entry is deliberately not stored: WB->ID needs no forwarding because the register file
// writes in the first half-cycle, so nothing would ever read it.
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_br_taken,
    output logic              fwd_a_mem,
    output logic              fwd_a_wb,
    output logic              fwd_b_mem,
    output logic              fwd_b_wb,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Hold counter only needs to reach LU_STALL-1, which is at most 2.
    localparam int CW = 2;

    typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic stall_c, cnt_inc;

    // Shadow EX entry.
    logic ex_valid_reg, ex_regwrite_reg, ex_memread_reg;
    logic [REG_AW-1:0] ex_rd_reg;
    // Shadow MEM entry (memread is not needed once a load has left EX).
    logic mem_valid_reg, mem_regwrite_reg;
    logic [REG_AW-1:0] mem_rd_reg;

    // Per-operand select registers: index 0 is operand A (rs), index 1 is operand B (rt).
    logic [1:0] fwd_mem_reg, fwd_wb_reg;
    logic [1:0] fwd_mem_next, fwd_wb_next;
    logic [REG_AW-1:0] src [2];

    logic ex_wt, mem_wt, lu;

    // Register 0 is hard-wired, so an entry targeting it never produces a forward.
    assign ex_wt  = ex_valid_reg & ex_regwrite_reg & (ex_rd_reg != '0);
    assign mem_wt = mem_valid_reg & mem_regwrite_reg & (mem_rd_reg != '0);

    assign lu = ex_valid_reg & ex_memread_reg & (ex_rd_reg != '0) &
                ((ex_rd_reg == id_rs) | (ex_rd_reg == id_rt)) & id_valid;

    assign src[0] = id_rs;
    assign src[1] = id_rt;

    // Forward selects for each operand; the newest producer (EX) wins over MEM.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_mem_next[gi] = id_valid & ex_wt & (ex_rd_reg == src[gi]);
            assign fwd_wb_next[gi]  = id_valid & mem_wt & (mem_rd_reg == src[gi]) &
                                      ~fwd_mem_next[gi];
        end
    endgenerate

    // Next-state and stall decode; a flush overrides both a fresh hazard and an ongoing hold.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_c    = 1'b0;
        cnt_inc    = 1'b0;
        if (ex_br_taken) begin
            state_next = RUN;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (lu) begin
                        stall_c  = 1'b1;
                        cnt_inc  = 1'b1;
                        cnt_next = CW'(LU_STALL - 1);
                        if (LU_STALL > 1) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    stall_c  = 1'b1;
                    cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;
                    if (cnt_reg <= CW'(1)) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign stall  = stall_c;
    assign bubble = ex_br_taken | stall_c;

    // FSM state, hold counter and saturating hazard-event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (cnt_inc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    // Shadow pipe: a bubble enters EX as an invalid entry; MEM follows EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg     <= 1'b0;
            ex_rd_reg        <= '0;
            ex_regwrite_reg  <= 1'b0;
            ex_memread_reg   <= 1'b0;
            mem_valid_reg    <= 1'b0;
            mem_rd_reg       <= '0;
            mem_regwrite_reg <= 1'b0;
        end else begin
            if (bubble) begin
                ex_valid_reg    <= 1'b0;
                ex_rd_reg       <= '0;
                ex_regwrite_reg <= 1'b0;
                ex_memread_reg  <= 1'b0;
            end else begin
                ex_valid_reg    <= id_valid;
                ex_rd_reg       <= id_rd;
                ex_regwrite_reg <= id_regwrite;
                ex_memread_reg  <= id_memread;
            end
            mem_valid_reg    <= ex_valid_reg;
            mem_rd_reg       <= ex_rd_reg;
            mem_regwrite_reg <= ex_regwrite_reg;
        end
    end

    // Selects are captured on the edge that moves ID into EX; a bubble clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_mem_reg <= '0;
            fwd_wb_reg  <= '0;
        end else if (bubble) begin
            fwd_mem_reg <= '0;
            fwd_wb_reg  <= '0;
        end else begin
            fwd_mem_reg <= fwd_mem_next;
            fwd_wb_reg  <= fwd_wb_next;
        end
    end

    assign fwd_a_mem = fwd_mem_reg[0];
    assign fwd_a_wb  = fwd_wb_reg[0];
    assign fwd_b_mem = fwd_mem_reg[1];
    assign fwd_b_wb  = fwd_wb_reg[1];
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: a default instance (LU_STALL=1) and a second instance with
// LU_STALL=3, CNT_W=2 for multi-cycle holds, counter saturation and reset mid-hold.
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n, rst3_n;
    logic id_valid, id_regwrite, id_memread, ex_br_taken;
    logic [4:0] id_rs, id_rt, id_rd;

    logic a_mem1, a_wb1, b_mem1, b_wb1, stall1, bubble1;
    logic [15:0] cnt1;
    logic a_mem3, a_wb3, b_mem3, b_wb3, stall3, bubble3;
    logic [1:0] cnt3;

    logic use3;
    logic [3:0] o_fwd;
    logic o_stall, o_bubble;
    logic [15:0] o_cnt;

    typedef struct packed {
        logic [3:0]  fwd;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q [$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_br_taken(ex_br_taken), .fwd_a_mem(a_mem1), .fwd_a_wb(a_wb1),
        .fwd_b_mem(b_mem1), .fwd_b_wb(b_wb1), .stall(stall1), .bubble(bubble1),
        .stall_cnt(cnt1)
    );

    fwd_hazard_ctrl #(.REG_AW(5), .LU_STALL(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_br_taken(ex_br_taken), .fwd_a_mem(a_mem3), .fwd_a_wb(a_wb3),
        .fwd_b_mem(b_mem3), .fwd_b_wb(b_wb3), .stall(stall3), .bubble(bubble3),
        .stall_cnt(cnt3)
    );

    // Observed outputs of whichever instance is under test; fwd order {a_mem,a_wb,b_mem,b_wb}.
    assign o_fwd    = use3 ? {a_mem3, a_wb3, b_mem3, b_wb3} : {a_mem1, a_wb1, b_mem1, b_wb1};
    assign o_stall  = use3 ? stall3 : stall1;
    assign o_bubble = use3 ? bubble3 : bubble1;
    assign o_cnt    = use3 ? {14'd0, cnt3} : cnt1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One ID cycle: drive just after the edge, check stall/bubble mid-cycle, queue the
    // expected registered outputs, then pop and compare them after the next edge.
    task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic br,
                        input logic est, input logic ebb, input logic [3:0] efwd,
                        input logic [15:0] ecnt);
        exp_t e;
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_regwrite = rw; id_memread = mr; ex_br_taken = br;
        #4;
        chk({tag, ".stall"}, 32'(o_stall), 32'(est));
        chk({tag, ".bubble"}, 32'(o_bubble), 32'(ebb));
        exp_q.push_back('{fwd: efwd, cnt: ecnt});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk({tag, ".fwd"}, 32'(o_fwd), 32'(e.fwd));
        chk({tag, ".cnt"}, 32'(o_cnt), 32'(e.cnt));
        $display("step %s v=%0b rs=%0d rt=%0d rd=%0d rw=%0b mr=%0b br=%0b fwd=%b stall=%0b cnt=%0d",
                 tag, v, rs, rt, rd, rw, mr, br, o_fwd, est, o_cnt);
    endtask

    task automatic nops(input logic [15:0] ecnt);
        step("nop", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, ecnt);
        step("nop", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, ecnt);
    endtask

    // Full LU_STALL=3 event: lw r7, then add r8,r7,r1 stalled for three cycles and issued.
    task automatic lu_event3(input logic [15:0] cprev, input logic [15:0] cnew);
        step("e3.lw",   1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, cprev);
        step("e3.lu",   1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, cnew);
        step("e3.h1",   1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, cnew);
        step("e3.h2",   1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, cnew);
        step("e3.go",   1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, cnew);
    endtask

    initial begin
        use3 = 1'b0;
        rst_n = 1'b0; rst3_n = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; ex_br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.fwd", 32'(o_fwd), 32'd0);
        chk("rst.stall", 32'(o_stall), 32'd0);
        chk("rst.bubble", 32'(o_bubble), 32'd0);
        chk("rst.cnt", 32'(o_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: back-to-back dependency forwards from EX/MEM on both operands.
        step("t1.add3",  1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
        step("t1.add4",  1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 16'd0);
        nops(16'd0);
        // 2: one instruction apart forwards from MEM/WB on operand A only.
        step("t2.add3",  1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
        step("t2.nop",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
        step("t2.sub",   1'b1, 5'd3, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 16'd0);
        nops(16'd0);
        // 3: two producers of r3; the newer one wins.
        step("t3.add3a", 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
        step("t3.add3b", 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
        step("t3.or6",   1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 16'd0);
        nops(16'd0);
        // 4: load-use, one bubble, then forward from MEM/WB.
        step("t4.lw7",   1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
        step("t4.lu",    1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 16'd1);
        step("t4.add8",  1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 16'd1);
        nops(16'd1);
        // 5: flush in the hazard cycle: bubble only, counter unchanged.
        step("t5.lw7",   1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
        step("t5.flush", 1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 16'd1);
        nops(16'd1);
        // 6: r0 destination never forwards or stalls; invalid ID never forwards.
        step("t6.addi0", 1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
        step("t6.use0",  1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
        step("t6.lw0",   1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
        step("t6.lduse0",1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
        step("t6.add3",  1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
        step("t6.inval", 1'b0, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
        nops(16'd1);

        // LU_STALL=3, CNT_W=2 instance.
        use3 = 1'b1;
        rst3_n = 1'b1;
        nops(16'd0);
        lu_event3(16'd0, 16'd1);
        nops(16'd1);
        // Flush during HOLD ends the hold at once without counting.
        step("h.lw7",    1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
        step("h.lu",     1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 16'd2);
        step("h.flush",  1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 16'd2);
        step("h.after",  1'b1, 5'd2, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd2);
        nops(16'd2);
        // Counter saturates at 3 with CNT_W=2.
        lu_event3(16'd2, 16'd3);
        nops(16'd3);
        lu_event3(16'd3, 16'd3);
        nops(16'd3);
        // Reset asserted mid-HOLD clears everything immediately; the hazard is not replayed.
        step("r.lw7",    1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd3);
        step("r.lu",     1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 16'd3);
        #4;
        chk("r.hold.stall", 32'(o_stall), 32'd1);
        rst3_n = 1'b0;
        #1;
        chk("r.rst.stall", 32'(o_stall), 32'd0);
        chk("r.rst.bubble", 32'(o_bubble), 32'd0);
        chk("r.rst.fwd", 32'(o_fwd), 32'd0);
        chk("r.rst.cnt", 32'(o_cnt), 32'd0);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        step("r.after",  1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
        step("r.next",   1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
